// File: rtl/legv8_decode_pkg.sv
// Shared definitions for the LEGv8 ID stage: opcodes, ALU encodings,
// control-word layout and the ID/EX register field map.
package legv8_decode_pkg;

   // Opcode patterns, each compared against the top bits of the instruction
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [10:0] OP_ADDS = 11'b10101011000;
   localparam logic [10:0] OP_SUBS = 11'b11101011000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_BR   = 11'b11010110000;
   localparam logic [5:0]  OP_B    = 6'b000101;
   localparam logic [5:0]  OP_BL   = 6'b100101;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;

   localparam logic [2:0] ALU_NONE = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b011;

   // Control word bit positions, LSB first
   localparam int CTRL_W      = 12;
   localparam int C_REGWRITE  = 0;
   localparam int C_MEMWRITE  = 1;
   localparam int C_MEMREAD   = 2;
   localparam int C_MEMTOREG  = 3;
   localparam int C_ALUSRC    = 4;
   localparam int C_ALUOP_LSB = 5;
   localparam int C_SETFLAGS  = 8;
   localparam int C_LINK      = 9;
   localparam int C_VALID     = 10;
   localparam int C_ILLEGAL   = 11;

   // ID/EX register layout
   localparam int DECODE_REG_W = 273;
   localparam int F_PC_LSB     = 0;
   localparam int F_RD1_LSB    = 64;
   localparam int F_RD2_LSB    = 128;
   localparam int F_IMM_LSB    = 192;
   localparam int F_RD_LSB     = 256;
   localparam int F_CTRL_LSB   = 261;

   // Packed so that reg_write lands on bit 0 of the control word
   typedef struct packed {
      logic       illegal;
      logic       valid;
      logic       link;
      logic       set_flags;
      logic [2:0] alu_op;
      logic       alu_src;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
   } ctrl_t;

   // Source of a resolved operand
   typedef enum logic [1:0] {
      SEL_RF   = 2'd0,
      SEL_ZERO = 2'd1,
      SEL_EX   = 2'd2,
      SEL_MEM  = 2'd3
   } opsel_t;

endpackage

// File: rtl/decode_hazard_unit.sv
// Operand forwarding selection and load-use hazard detection for ID.
module decode_hazard_unit
   import legv8_decode_pkg::*;
#(
   parameter logic [4:0] ZERO_REG = 5'd31
) (
   input  logic       i_slot_valid,
   input  logic [4:0] i_src1,
   input  logic [4:0] i_src2,
   input  logic       i_use1,
   input  logic       i_use2,
   input  logic       i_ex_reg_write,
   input  logic       i_ex_mem_read,
   input  logic [4:0] i_ex_rd,
   input  logic       i_mem_fwd_en,
   input  logic [4:0] i_mem_fwd_rd,
   output opsel_t     o_sel1,
   output opsel_t     o_sel2,
   output logic       o_stall
);

   // XZR beats everything; a load in EX cannot forward (its data is not ready)
   function automatic opsel_t pick(input logic [4:0] src, input logic ex_rw,
                                   input logic ex_mr, input logic [4:0] ex_rd,
                                   input logic mem_en, input logic [4:0] mem_rd);
      if (src == ZERO_REG)                  return SEL_ZERO;
      if (ex_rw && !ex_mr && ex_rd == src)  return SEL_EX;
      if (mem_en && mem_rd == src)          return SEL_MEM;
      return SEL_RF;
   endfunction

   // Select operand sources and detect a load feeding the next instruction
   always_comb begin
      o_sel1  = pick(i_src1, i_ex_reg_write, i_ex_mem_read, i_ex_rd, i_mem_fwd_en, i_mem_fwd_rd);
      o_sel2  = pick(i_src2, i_ex_reg_write, i_ex_mem_read, i_ex_rd, i_mem_fwd_en, i_mem_fwd_rd);
      o_stall = i_slot_valid && i_ex_mem_read && (i_ex_rd != ZERO_REG) &&
                ((i_use1 && i_src1 == i_ex_rd) || (i_use2 && i_src2 == i_ex_rd));
   end

endmodule

// File: rtl/instruction_decode_unit.sv
// LEGv8 ID stage: decode, operand resolution, early branch resolution,
// load-use stall and the registered ID/EX pipeline register.
module instruction_decode_unit
   import legv8_decode_pkg::*;
#(
   parameter logic [4:0] LINK_REG = 5'd30,
   parameter logic [4:0] ZERO_REG = 5'd31
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [95:0]             INSTRUCTION_PIPELINE_REG,
   output logic [4:0]              rf_rd_addr1,
   output logic [4:0]              rf_rd_addr2,
   input  logic [63:0]             rf_rd_data1,
   input  logic [63:0]             rf_rd_data2,
   input  logic [63:0]             ex_fwd_data,
   input  logic                    mem_fwd_en,
   input  logic [4:0]              mem_fwd_rd,
   input  logic [63:0]             mem_fwd_data,
   output logic [63:0]             BranchAddress,
   output logic                    BrTaken_Ctrl,
   output logic                    Stall_Ctrl,
   output logic                    Illegal_Flag,
   output logic [DECODE_REG_W-1:0] DECODE_PIPELINE_REG
);

   logic [63:0]             w_pc;
   logic [31:0]             w_instr;
   ctrl_t                   w_ctrl;
   logic [4:0]              w_rd;
   logic [4:0]              w_src2;
   logic [63:0]             w_imm;
   logic                    w_use1, w_use2;
   logic                    w_is_b, w_is_br, w_is_cbz;
   opsel_t                  w_sel1, w_sel2;
   logic                    w_stall;
   logic [63:0]             w_op1, w_op2;
   logic                    w_take;
   logic [DECODE_REG_W-1:0] w_idex_next;

   logic                    r_flush_q;
   logic                    r_illegal;
   logic [DECODE_REG_W-1:0] r_idex;

   function automatic logic [63:0] resolve(input opsel_t sel, input logic [63:0] rf,
                                           input logic [63:0] ex, input logic [63:0] mem);
      case (sel)
         SEL_ZERO: return 64'd0;
         SEL_EX:   return ex;
         SEL_MEM:  return mem;
         default:  return rf;
      endcase
   endfunction

   assign w_pc    = INSTRUCTION_PIPELINE_REG[95:32];
   assign w_instr = INSTRUCTION_PIPELINE_REG[31:0];

   // Decode the opcode into control, destination, immediate and source usage
   always_comb begin
      w_ctrl   = '0;
      w_rd     = w_instr[4:0];
      w_src2   = w_instr[20:16];
      w_imm    = '0;
      w_use1   = 1'b0;
      w_use2   = 1'b0;
      w_is_b   = 1'b0;
      w_is_br  = 1'b0;
      w_is_cbz = 1'b0;
      if (w_instr[31:22] == OP_ADDI) begin
         w_ctrl.reg_write = 1'b1;
         w_ctrl.alu_src   = 1'b1;
         w_ctrl.alu_op    = ALU_ADD;
         w_ctrl.valid     = 1'b1;
         w_imm            = {52'd0, w_instr[21:10]};
         w_use1           = 1'b1;
      end else if (w_instr[31:21] == OP_ADDS || w_instr[31:21] == OP_SUBS) begin
         w_ctrl.reg_write = 1'b1;
         w_ctrl.alu_op    = (w_instr[31:21] == OP_SUBS) ? ALU_SUB : ALU_ADD;
         w_ctrl.set_flags = 1'b1;
         w_ctrl.valid     = 1'b1;
         w_use1           = 1'b1;
         w_use2           = 1'b1;
      end else if (w_instr[31:21] == OP_LDUR) begin
         w_ctrl.reg_write  = 1'b1;
         w_ctrl.mem_read   = 1'b1;
         w_ctrl.mem_to_reg = 1'b1;
         w_ctrl.alu_src    = 1'b1;
         w_ctrl.alu_op     = ALU_ADD;
         w_ctrl.valid      = 1'b1;
         w_imm             = {{55{w_instr[20]}}, w_instr[20:12]};
         w_use1            = 1'b1;
      end else if (w_instr[31:21] == OP_STUR) begin
         w_ctrl.mem_write = 1'b1;
         w_ctrl.alu_src   = 1'b1;
         w_ctrl.alu_op    = ALU_ADD;
         w_ctrl.valid     = 1'b1;
         w_imm            = {{55{w_instr[20]}}, w_instr[20:12]};
         w_src2           = w_instr[4:0];
         w_use1           = 1'b1;
         w_use2           = 1'b1;
      end else if (w_instr[31:21] == OP_BR) begin
         w_ctrl.valid = 1'b1;
         w_is_br      = 1'b1;
         w_use1       = 1'b1;
      end else if (w_instr[31:26] == OP_B) begin
         w_ctrl.valid = 1'b1;
         w_rd         = ZERO_REG;
         w_imm        = {{36{w_instr[25]}}, w_instr[25:0], 2'b00};
         w_is_b       = 1'b1;
      end else if (w_instr[31:26] == OP_BL) begin
         w_ctrl.reg_write = 1'b1;
         w_ctrl.link      = 1'b1;
         w_ctrl.valid     = 1'b1;
         w_rd             = LINK_REG;
         w_imm            = {{36{w_instr[25]}}, w_instr[25:0], 2'b00};
         w_is_b           = 1'b1;
      end else if (w_instr[31:24] == OP_CBZ) begin
         w_ctrl.valid = 1'b1;
         w_imm        = {{43{w_instr[23]}}, w_instr[23:5], 2'b00};
         w_src2       = w_instr[4:0];
         w_is_cbz     = 1'b1;
         w_use2       = 1'b1;
      end else if (w_instr != 32'd0) begin
         w_ctrl.illegal = 1'b1;
      end
   end

   assign rf_rd_addr1 = w_instr[9:5];
   assign rf_rd_addr2 = w_src2;

   decode_hazard_unit #(.ZERO_REG(ZERO_REG)) u_hazard (
      .i_slot_valid   (w_ctrl.valid && !r_flush_q),
      .i_src1         (w_instr[9:5]),
      .i_src2         (w_src2),
      .i_use1         (w_use1),
      .i_use2         (w_use2),
      .i_ex_reg_write (r_idex[F_CTRL_LSB + C_REGWRITE]),
      .i_ex_mem_read  (r_idex[F_CTRL_LSB + C_MEMREAD]),
      .i_ex_rd        (r_idex[F_RD_LSB +: 5]),
      .i_mem_fwd_en   (mem_fwd_en),
      .i_mem_fwd_rd   (mem_fwd_rd),
      .o_sel1         (w_sel1),
      .o_sel2         (w_sel2),
      .o_stall        (w_stall)
   );

   // Resolve operands and the branch decision; a flushed slot does nothing
   always_comb begin
      w_op1         = resolve(w_sel1, rf_rd_data1, ex_fwd_data, mem_fwd_data);
      w_op2         = resolve(w_sel2, rf_rd_data2, ex_fwd_data, mem_fwd_data);
      w_take        = w_is_b || w_is_br || (w_is_cbz && w_op2 == 64'd0);
      BranchAddress = w_is_br ? w_op1 : (w_pc + w_imm);
      Stall_Ctrl    = w_stall;
      BrTaken_Ctrl  = !r_flush_q && !w_stall && w_take;
   end

   // Build the next ID/EX value; flush and stall both insert a zero bubble
   always_comb begin
      w_idex_next = '0;
      if (!r_flush_q && !w_stall) begin
         if (w_ctrl.valid)
            w_idex_next = {w_ctrl, w_rd, w_imm, w_op2, w_op1, w_pc};
         else
            w_idex_next[F_CTRL_LSB + C_ILLEGAL] = w_ctrl.illegal;
      end
   end

   // ID/EX register, wrong-path flush marker and sticky illegal flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idex    <= '0;
         r_flush_q <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_idex    <= w_idex_next;
         r_flush_q <= BrTaken_Ctrl;
         if (!r_flush_q && w_ctrl.illegal)
            r_illegal <= 1'b1;
      end
   end

   assign DECODE_PIPELINE_REG = r_idex;
   assign Illegal_Flag        = r_illegal;

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Self-checking bench for instruction_decode_unit: a vector table of
// straight-line instructions plus hand sequences for branches, flush,
// load-use stall, forwarding, illegal opcodes and mid-flush reset.
module tb_instruction_decode_unit;

   localparam logic [11:0] K_ADDI = 12'h451;
   localparam logic [11:0] K_ADDS = 12'h541;
   localparam logic [11:0] K_SUBS = 12'h561;
   localparam logic [11:0] K_STUR = 12'h452;
   localparam logic [11:0] K_LDUR = 12'h45D;
   localparam logic [11:0] K_BR   = 12'h400;
   localparam logic [11:0] K_BL   = 12'h601;
   localparam logic [11:0] K_ILL  = 12'h800;

   logic         clk = 1'b0;
   logic         reset;
   logic [95:0]  ifid;
   logic [4:0]   rf_rd_addr1, rf_rd_addr2;
   logic [63:0]  rf_rd_data1, rf_rd_data2, ex_fwd_data, mem_fwd_data;
   logic         mem_fwd_en;
   logic [4:0]   mem_fwd_rd;
   logic [63:0]  BranchAddress;
   logic         BrTaken_Ctrl, Stall_Ctrl, Illegal_Flag;
   logic [272:0] idex;

   instruction_decode_unit dut (
      .clk                      (clk),
      .reset                    (reset),
      .INSTRUCTION_PIPELINE_REG (ifid),
      .rf_rd_addr1              (rf_rd_addr1),
      .rf_rd_addr2              (rf_rd_addr2),
      .rf_rd_data1              (rf_rd_data1),
      .rf_rd_data2              (rf_rd_data2),
      .ex_fwd_data              (ex_fwd_data),
      .mem_fwd_en               (mem_fwd_en),
      .mem_fwd_rd               (mem_fwd_rd),
      .mem_fwd_data             (mem_fwd_data),
      .BranchAddress            (BranchAddress),
      .BrTaken_Ctrl             (BrTaken_Ctrl),
      .Stall_Ctrl               (Stall_Ctrl),
      .Illegal_Flag             (Illegal_Flag),
      .DECODE_PIPELINE_REG      (idex)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   logic [272:0] sb_q[$];

   typedef struct {
      string        nm;
      logic [63:0]  pc;
      logic [31:0]  ins;
      logic [63:0]  rf1;
      logic [63:0]  rf2;
      logic [4:0]   a1;
      logic [4:0]   a2;
      logic [272:0] exp;
   } vec_t;

   function automatic logic [272:0] mk(input logic [11:0] c, input logic [4:0] rd,
                                       input logic [63:0] imm, input logic [63:0] rd2,
                                       input logic [63:0] rd1, input logic [63:0] pc);
      return {c, rd, imm, rd2, rd1, pc};
   endfunction

   task automatic check(input string nm, input logic [272:0] act, input logic [272:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Drive one IF/ID slot, check combinational outputs mid-cycle, then the ID/EX result
   task automatic slot(input string nm, input logic [63:0] pc, input logic [31:0] ins,
                       input logic [63:0] rf1, input logic [63:0] rf2, input logic [63:0] exf,
                       input logic men, input logic [4:0] mrd, input logic [63:0] mdat,
                       input logic ca, input logic [63:0] eaddr, input logic ebr,
                       input logic est, input logic [272:0] eid);
      ifid         = {pc, ins};
      rf_rd_data1  = rf1;
      rf_rd_data2  = rf2;
      ex_fwd_data  = exf;
      mem_fwd_en   = men;
      mem_fwd_rd   = mrd;
      mem_fwd_data = mdat;
      #3;
      if (ca) check({nm, ".addr"}, 273'(BranchAddress), 273'(eaddr));
      check({nm, ".br"}, 273'(BrTaken_Ctrl), 273'(ebr));
      check({nm, ".stall"}, 273'(Stall_Ctrl), 273'(est));
      sb_q.push_back(eid);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) check({nm, ".queue"}, 273'd1, 273'd0);
      else check({nm, ".idex"}, idex, sb_q.pop_front());
   endtask

   task automatic simple(input string nm, input logic [63:0] pc, input logic [31:0] ins,
                         input logic [63:0] rf1, input logic [63:0] rf2, input logic [272:0] eid);
      slot(nm, pc, ins, rf1, rf2, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, eid);
   endtask

   task automatic branch(input string nm, input logic [63:0] pc, input logic [31:0] ins,
                         input logic [63:0] rf1, input logic [63:0] rf2,
                         input logic [63:0] eaddr, input logic ebr, input logic [272:0] eid);
      slot(nm, pc, ins, rf1, rf2, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, eaddr, ebr, 1'b0, eid);
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{"addi_x1_xzr", 64'h10, 32'h910017E1, 64'hAAAA, 64'hB0, 5'd31, 5'd0,
                 mk(K_ADDI, 5'd1, 64'd5, 64'hB0, 64'd0, 64'h10)};
      tbl[1] = '{"adds",  64'h14, 32'hAB0700C5, 64'h11, 64'h22, 5'd6, 5'd7,
                 mk(K_ADDS, 5'd5, 64'd0, 64'h22, 64'h11, 64'h14)};
      tbl[2] = '{"subs",  64'h18, 32'hEB0A0128, 64'h33, 64'h44, 5'd9, 5'd10,
                 mk(K_SUBS, 5'd8, 64'd0, 64'h44, 64'h33, 64'h18)};
      tbl[3] = '{"stur_neg", 64'h1C, 32'hF81F818B, 64'h55, 64'h66, 5'd12, 5'd11,
                 mk(K_STUR, 5'd11, 64'hFFFF_FFFF_FFFF_FFF8, 64'h66, 64'h55, 64'h1C)};
      tbl[4] = '{"ldur",  64'h20, 32'hF8410023, 64'h77, 64'h88, 5'd1, 5'd1,
                 mk(K_LDUR, 5'd3, 64'd16, 64'h88, 64'h77, 64'h20)};
      tbl[5] = '{"addi_indep", 64'h24, 32'h910005CD, 64'h99, 64'hAA, 5'd14, 5'd0,
                 mk(K_ADDI, 5'd13, 64'd1, 64'hAA, 64'h99, 64'h24)};
      tbl[6] = '{"addi_max", 64'h28, 32'h913FFC42, 64'hBB, 64'hCC, 5'd2, 5'd31,
                 mk(K_ADDI, 5'd2, 64'hFFF, 64'd0, 64'hBB, 64'h28)};

      reset = 1'b1;
      ifid = '0;
      rf_rd_data1 = '0; rf_rd_data2 = '0; ex_fwd_data = '0;
      mem_fwd_en = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.idex", idex, 273'd0);
      check("reset.illegal", 273'(Illegal_Flag), 273'd0);
      reset = 1'b0;
      simple("nop", 64'h0, 32'h0, 64'h0, 64'h0, 273'd0);

      for (int i = 0; i < 7; i++) begin
         ifid = {tbl[i].pc, tbl[i].ins};
         #1;
         check({tbl[i].nm, ".a1"}, 273'(rf_rd_addr1), 273'(tbl[i].a1));
         check({tbl[i].nm, ".a2"}, 273'(rf_rd_addr2), 273'(tbl[i].a2));
         simple(tbl[i].nm, tbl[i].pc, tbl[i].ins, tbl[i].rf1, tbl[i].rf2, tbl[i].exp);
      end

      // Unconditional branches and the wrong-path flush behind each
      branch("b_fwd", 64'h40, 32'h14000004, 64'h1, 64'h2, 64'h50, 1'b1,
             mk(K_BR, 5'd31, 64'h10, 64'h2, 64'h1, 64'h40));
      simple("b_fwd_flush", 64'h44, 32'h910005CD, 64'h9, 64'h9, 273'd0);
      branch("b_back", 64'h8, 32'h17FFFFFF, 64'h1, 64'h2, 64'h4, 1'b1,
             mk(K_BR, 5'd31, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 64'h8));
      simple("b_back_flush", 64'hC, 32'h0, 64'h0, 64'h0, 273'd0);
      branch("b_wrap", 64'hFFFF_FFFF_FFFF_FFF8, 32'h14000004, 64'h3, 64'h4, 64'h8, 1'b1,
             mk(K_BR, 5'd31, 64'h10, 64'h4, 64'h3, 64'hFFFF_FFFF_FFFF_FFF8));
      simple("b_wrap_flush", 64'h0, 32'h0, 64'h0, 64'h0, 273'd0);

      // CBZ taken, then not taken with no flush on the following slot
      branch("cbz_taken", 64'h20, 32'hB4000062, 64'h5, 64'h0, 64'h2C, 1'b1,
             mk(K_BR, 5'd2, 64'hC, 64'h0, 64'h5, 64'h20));
      branch("cbz_flush", 64'h24, 32'hB4000062, 64'h5, 64'h7, 64'h30, 1'b0, 273'd0);
      branch("cbz_not", 64'h20, 32'hB4000062, 64'h5, 64'h7, 64'h2C, 1'b0,
             mk(K_BR, 5'd2, 64'hC, 64'h7, 64'h5, 64'h20));
      simple("after_cbz", 64'h24, 32'h910005CD, 64'h99, 64'hAA,
             mk(K_ADDI, 5'd13, 64'd1, 64'hAA, 64'h99, 64'h24));

      // BL writes the link register
      branch("bl", 64'h100, 32'h94000010, 64'h3, 64'h4, 64'h140, 1'b1,
             mk(K_BL, 5'd30, 64'h40, 64'h4, 64'h3, 64'h100));
      simple("bl_flush", 64'h104, 32'h0, 64'h0, 64'h0, 273'd0);

      // BR on a register produced by the instruction in EX; EX wins over MEM
      simple("adds_x5", 64'h300, 32'hAB0700C5, 64'h11, 64'h22,
             mk(K_ADDS, 5'd5, 64'd0, 64'h22, 64'h11, 64'h300));
      slot("br_exfwd", 64'h304, 32'hD61F00A0, 64'hDEAD, 64'hBEEF, 64'h1234_5678_9ABC,
           1'b1, 5'd5, 64'h777, 1'b1, 64'h1234_5678_9ABC, 1'b1, 1'b0,
           mk(K_BR, 5'd0, 64'd0, 64'd0, 64'h1234_5678_9ABC, 64'h304));
      simple("br_flush", 64'h308, 32'h0, 64'h0, 64'h0, 273'd0);

      // Load-use: one stall cycle, then MEM forwarding supplies both operands
      simple("ldur_x3", 64'h200, 32'hF8400023, 64'h10, 64'h20,
             mk(K_LDUR, 5'd3, 64'd0, 64'h20, 64'h10, 64'h200));
      slot("use_stall", 64'h204, 32'hAB030064, 64'hDEAD, 64'hDEAD, 64'd0,
           1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 273'd0);
      slot("use_memfwd", 64'h204, 32'hAB030064, 64'hDEAD, 64'hDEAD, 64'd0,
           1'b1, 5'd3, 64'h99, 1'b0, 64'd0, 1'b0, 1'b0,
           mk(K_ADDS, 5'd4, 64'd0, 64'h99, 64'h99, 64'h204));

      // A load into XZR is never a hazard source
      simple("ldur_xzr", 64'h210, 32'hF840003F, 64'h10, 64'h20,
             mk(K_LDUR, 5'd31, 64'd0, 64'h20, 64'h10, 64'h210));
      simple("adds_xzr", 64'h214, 32'hAB1F03E4, 64'h5, 64'h6,
             mk(K_ADDS, 5'd4, 64'd0, 64'd0, 64'd0, 64'h214));

      // Illegal opcode: bubble with Illegal set, flag sticky
      check("illegal.pre", 273'(Illegal_Flag), 273'd0);
      simple("illegal", 64'h500, 32'hFFFF_FFFF, 64'h1, 64'h2, mk(K_ILL, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0));
      check("illegal.flag", 273'(Illegal_Flag), 273'd1);
      simple("after_ill", 64'h504, 32'h910005CD, 64'h7, 64'h8,
             mk(K_ADDI, 5'd13, 64'd1, 64'h8, 64'h7, 64'h504));
      check("illegal.sticky", 273'(Illegal_Flag), 273'd1);

      // Reset while a flush is pending; the next slot must decode normally
      branch("b_pre_rst", 64'h40, 32'h14000004, 64'h1, 64'h2, 64'h50, 1'b1,
             mk(K_BR, 5'd31, 64'h10, 64'h2, 64'h1, 64'h40));
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst2.idex", idex, 273'd0);
      check("rst2.illegal", 273'(Illegal_Flag), 273'd0);
      simple("post_rst", 64'h44, 32'h910005CD, 64'h99, 64'hAA,
             mk(K_ADDI, 5'd13, 64'd1, 64'hAA, 64'h99, 64'h44));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/instruction_decode_unit.md
Name: instruction_decode_unit

Overview:
LEGv8 ID stage and the consumer end of the IF/ID interface. It takes the 96-bit {PC, instr} IF pipeline register, decodes the instruction, and reads the register file through its read-port interface. It resolves B/BL/BR/CBZ in ID, drives BranchAddress and BrTaken_Ctrl back to fetch, and detects load-use hazards, raising Stall_Ctrl. Its output is the registered ID/EX pipeline register.

Parameters:
LINK_REG, 30, register written with PC+4 by BL
ZERO_REG, 31, XZR: reads as 0, never written, never forwarded, never a hazard source

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
INSTRUCTION_PIPELINE_REG  in  96  IF/ID register: [95:32]=PC, [31:0]=instr
rf_rd_addr1  out  5  regfile read address A (Rn; Rn for BR)
rf_rd_addr2  out  5  regfile read address B (Rm for R-type; Rt for STUR/CBZ)
rf_rd_data1  in  64  combinational read data A (regfile is write-before-read)
rf_rd_data2  in  64  combinational read data B
ex_fwd_data  in  64  ALU result of the instruction currently in EX
mem_fwd_en  in  1  MEM-stage instruction writes a register
mem_fwd_rd  in  5  MEM-stage destination
mem_fwd_data  in  64  MEM-stage result (load data or ALU result)
BranchAddress  out  64  branch target, combinational
BrTaken_Ctrl  out  1  redirect fetch this cycle
Stall_Ctrl  out  1  fetch must hold its PC and IF/ID register this cycle
Illegal_Flag  out  1  sticky: an unrecognised non-zero opcode was decoded
DECODE_PIPELINE_REG  out  273  ID/EX register: [63:0]=PC, [127:64]=rd1, [191:128]=rd2, [255:192]=imm, [260:256]=Rd, [272:261]=ctrl

Behaviour:
- ctrl bit order, LSB first: RegWrite, MemWrite, MemRead, MemToReg, ALUSrc, ALUOp[2:0], SetFlags, Link, Valid, Illegal.
- ALUOp encoding: 010=ADD, 011=SUB, 000=none.
- Supported opcodes:
  - ADDI (1001000100): imm12 [21:10], zero-extended; ALUSrc=1.
  - ADDS (10101011000), SUBS (11101011000): SetFlags=1.
  - LDUR (11111000010), STUR (11111000000): imm9 [20:12], sign-extended.
  - B (000101): imm26, sign-extended and <<2.
  - BL (100101): as B; Rd=LINK_REG, RegWrite=1, Link=1.
  - CBZ (10110100): imm19 [23:5], sign-extended and <<2; tests Rt.
  - BR (11010110000): target = Rn.
- instr==0 decodes as a bubble (all ctrl 0). Any other unknown opcode is also a bubble, with Illegal=1 in ctrl and Illegal_Flag set until reset.
- Reset: DECODE_PIPELINE_REG=0, Illegal_Flag=0, flush_q=0. BrTaken_Ctrl=0 and Stall_Ctrl=0 whenever the decoded slot is a bubble.
- Latency: DECODE_PIPELINE_REG reflects the IF/ID contents one cycle later. BranchAddress, BrTaken_Ctrl and Stall_Ctrl are combinational from current IF/ID and ID/EX state.
- BranchAddress: PC + offset (64-bit wrap) for B/BL/CBZ; resolved Rn value for BR.
- BrTaken_Ctrl=1 for B, BL and BR. For CBZ it is 1 only when the resolved Rt value == 0.
- Branch flush: on a cycle with BrTaken_Ctrl=1, flush_q is set for exactly one cycle. The next IF/ID slot is the wrong-path PC+4 and is decoded as a bubble, with no stall and no branch.
- Operand resolution priority, per source register:
  1. ZERO_REG reads as 0.
  2. EX forward (ID/EX RegWrite, Rd match, not MemRead) supplies ex_fwd_data.
  3. MEM forward (mem_fwd_en, mem_fwd_rd match) supplies mem_fwd_data.
  4. Otherwise the regfile data is used.
- rd1 and rd2 are latched into ID/EX after forwarding.
- Load-use hazard: ID/EX MemRead=1, ID/EX Rd != ZERO_REG, and Rd equals a source the current instruction actually uses. Response:
  - Stall_Ctrl=1 and BrTaken_Ctrl=0.
  - A bubble is written to ID/EX.
  - The stall lasts exactly one cycle; the dependent then resolves via MEM forwarding.
- Precedence: flush_q > stall > branch.
- Reset mid-stall or mid-flush clears all state; the first post-reset cycle decodes normally.

Decomposition:
- Package legv8_decode_pkg holds:
  - opcode localparams;
  - ALUOp encodings;
  - ctrl bit indices and CTRL_W=12;
  - DECODE_REG_W=273 and field offsets;
  - a decoded-control struct typedef.
- Sub-module decode_hazard_unit contains the forwarding selection and the load-use detection. Its outputs are operand selects and the stall signal.

Test Plan:
- Reset, then IF/ID = {PC=0x0, instr=0} → ID/EX all 0; BrTaken_Ctrl=0, Stall_Ctrl=0.
- {PC=0x10, 0x910017E1} (ADDI X1,XZR,#5) → next cycle: Rd=1, imm=5, rd1=0, ctrl RegWrite/ALUSrc/ALUOp=010/Valid.
- {PC=0x40, 0x14000004} (B +4 words) → BranchAddress=0x50, BrTaken_Ctrl=1. The following slot {0x44, any} becomes a bubble in ID/EX.
- CBZ X2 (0xB4000062) at PC=0x20, with rf_rd_data2=0 → BranchAddress=0x2C, taken. Repeat with rf_rd_data2=7 → not taken, no flush.
- LDUR X3,[X1] (0xF8400023), then ADDS X4,X3,X3 (0xAB030064) → one cycle of Stall_Ctrl=1 and a bubble. Next cycle, with mem_fwd_en=1, mem_fwd_rd=3, mem_fwd_data=0x99 → rd1=rd2=0x99.
- Unknown opcode 0xFFFFFFFF → bubble and Illegal_Flag=1, sticky through later valid instructions until reset.
